// File: rtl/ahb_sram_ctrl_if.sv
// ahb_sram_ctrl_if
//   AHB-Lite signal bundle between a bus master (or interconnect) and the
//   ahb_sram_ctrl slave.
//   Address phase : hsel, haddr, htrans, hwrite, hsize, hburst, hprot,
//                   hmastlock, hready_in
//   Data phase    : hwdata (master -> slave), hrdata, hready, hresp
//                   (slave -> master)
//   Modports: slave (the SRAM controller), master (the driving side).
interface ahb_sram_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
    logic                  hready_in;
    logic [DATA_WIDTH-1:0] hwdata;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hready;
    logic                  hresp;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
               hready_in, hwdata,
        output hrdata, hready, hresp
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
               hready_in, hwdata,
        input  hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl
//   AHB-Lite slave SRAM. Word-wide array with byte-lane writes derived from
//   HSIZE/HADDR, a programmable number of wait states per transfer, the
//   two-cycle ERROR response for out-of-range, oversized or misaligned
//   accesses, and read-after-write forwarding so back-to-back write->read to
//   the same word needs no dead cycle.
//   Ports:
//     HCLK     clock, rising edge
//     HRESETn  asynchronous active-low reset (array contents are kept)
//     bus      ahb_sram_ctrl_if.slave: address/data phase signals, hrdata,
//              hready, hresp
module ahb_sram_ctrl #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    SIZE_IN_KB  = 64,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
    parameter int                    WAIT_STATES = 0,
    parameter int                    INITIALIZE  = 0,
    parameter                        INIT_FILE   = "binary_rom_image.mem"
) (
    input logic            HCLK,
    input logic            HRESETn,
    ahb_sram_ctrl_if.slave bus
);

    localparam int BPW       = DATA_WIDTH / 8;
    localparam int LANE_W    = $clog2(BPW);
    localparam int DEPTH     = SIZE_IN_KB * 1024 / BPW;
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int MEM_BYTES = DEPTH * BPW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Lane enables for a transfer of 2**size bytes starting at byte 'lane'.
    function automatic logic [BPW-1:0] byte_mask(input logic [2:0]        size,
                                                 input logic [LANE_W-1:0] lane);
        logic [BPW-1:0] m;
        int first;
        int last;
        first = int'(lane);
        last  = first + (1 << size);
        for (int i = 0; i < BPW; i++) begin
            m[i] = (i >= first) && (i < last);
        end
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_bits(input logic [BPW-1:0] m);
        logic [DATA_WIDTH-1:0] b;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            b[i] = m[i/8];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t              state;
    logic [3:0]          cnt;
    logic [IDX_W-1:0]    idx_p0;
    logic [LANE_W-1:0]   lane_p0;
    logic [2:0]          size_p0;
    logic                write_p0;

    // Address-phase decode
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      new_idx;
    logic [LANE_W-1:0]     new_lane;
    logic                  accept;
    logic                  range_ok;
    logic                  size_ok;
    logic                  misaligned;
    logic                  addr_err;

    assign offset     = bus.haddr - START_ADDR;
    assign new_idx    = offset[LANE_W +: IDX_W];
    assign new_lane   = offset[LANE_W-1:0];
    assign accept     = bus.hsel & bus.htrans[1] & bus.hready_in;
    // An address below START_ADDR wraps to a huge offset and fails here too.
    assign range_ok   = 64'(offset) < 64'(MEM_BYTES);
    assign size_ok    = bus.hsize <= 3'(LANE_W);
    assign misaligned = |(new_lane & LANE_W'((1 << bus.hsize) - 1));
    assign addr_err   = !range_ok || !size_ok || misaligned;

    wire unused_bus = &{1'b0, bus.htrans[0], bus.hburst, bus.hprot, bus.hmastlock};

    // Write merge and read path
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_bits;
    logic [DATA_WIDTH-1:0] merged;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_en   = (state == ST_LAST) && write_p0;
    assign wr_bits = lane_bits(byte_mask(size_p0, lane_p0));
    assign merged  = (mem[idx_p0] & ~wr_bits) | (bus.hwdata & wr_bits);
    // A read leaving WAIT uses the captured index; a zero-wait read samples
    // the array on its own accept edge, so it uses the live address.
    assign rd_idx  = (state == ST_WAIT) ? idx_p0 : new_idx;
    assign rd_word = (wr_en && (idx_p0 == rd_idx)) ? merged : mem[rd_idx];

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem[idx_p0] <= merged;
        end
    end

    // ---- data-phase FSM: state, wait counter, captured transfer, outputs ----
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx_p0     <= '0;
            lane_p0    <= '0;
            size_p0    <= '0;
            write_p0   <= 1'b0;
            bus.hready <= 1'b1;
            bus.hresp  <= 1'b0;
            bus.hrdata <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_LAST, ST_ERR2: begin
                    state      <= ST_IDLE;
                    bus.hready <= 1'b1;
                    bus.hresp  <= 1'b0;
                    if (accept) begin
                        idx_p0   <= new_idx;
                        lane_p0  <= new_lane;
                        size_p0  <= bus.hsize;
                        write_p0 <= bus.hwrite & ~addr_err;
                        if (addr_err) begin
                            state      <= ST_ERR1;
                            bus.hready <= 1'b0;
                            bus.hresp  <= 1'b1;
                            bus.hrdata <= '0;
                        end else if (WAIT_STATES > 0) begin
                            state      <= ST_WAIT;
                            bus.hready <= 1'b0;
                            cnt        <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= ST_LAST;
                            if (!bus.hwrite) begin
                                bus.hrdata <= rd_word;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= ST_LAST;
                        bus.hready <= 1'b1;
                        if (!write_p0) begin
                            bus.hrdata <= rd_word;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state      <= ST_ERR2;
                    bus.hready <= 1'b1;
                    bus.hresp  <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    bus.hready <= 1'b1;
                    bus.hresp  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl
//   Directed bench for ahb_sram_ctrl. Two instances share one set of master
//   signals: u_dut0 (no wait states) and u_dut3 (three wait states); dut_sel
//   routes hsel to one of them and picks which outputs are observed.
module tb_ahb_sram_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        dut_sel = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    ahb_sram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    assign bus0.hsel      = hsel & ~dut_sel;
    assign bus0.haddr     = haddr;
    assign bus0.htrans    = htrans;
    assign bus0.hwrite    = hwrite;
    assign bus0.hsize     = hsize;
    assign bus0.hburst    = 3'b000;
    assign bus0.hprot     = 4'b0011;
    assign bus0.hmastlock = 1'b0;
    assign bus0.hready_in = bus0.hready;
    assign bus0.hwdata    = hwdata;

    assign bus3.hsel      = hsel & dut_sel;
    assign bus3.haddr     = haddr;
    assign bus3.htrans    = htrans;
    assign bus3.hwrite    = hwrite;
    assign bus3.hsize     = hsize;
    assign bus3.hburst    = 3'b000;
    assign bus3.hprot     = 4'b0011;
    assign bus3.hmastlock = 1'b0;
    assign bus3.hready_in = bus3.hready;
    assign bus3.hwdata    = hwdata;

    logic        hready_m;
    logic        hresp_m;
    logic [31:0] hrdata_m;
    assign hready_m = dut_sel ? bus3.hready : bus0.hready;
    assign hresp_m  = dut_sel ? bus3.hresp  : bus0.hresp;
    assign hrdata_m = dut_sel ? bus3.hrdata : bus0.hrdata;

    ahb_sram_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SIZE_IN_KB(64), .START_ADDR(32'h0),
        .WAIT_STATES(0), .INITIALIZE(0), .INIT_FILE("binary_rom_image.mem")
    ) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0)
    );

    ahb_sram_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SIZE_IN_KB(64), .START_ADDR(32'h0),
        .WAIT_STATES(3), .INITIALIZE(0), .INIT_FILE("binary_rom_image.mem")
    ) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One non-pipelined transfer. Returns the read data and hresp seen in the
    // final data-phase cycle, hready/hresp in the first data-phase cycle and
    // the number of hready-low data-phase cycles.
    task automatic ahb_xfer(input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int waits,
                            output logic rdy_first, output logic resp_first,
                            output logic resp_last);
        int n;
        @(negedge HCLK);
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
        n = 0;
        while (!hready_m && n < 50) begin
            @(negedge HCLK);
            n++;
        end
        @(negedge HCLK);
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
        rdy_first  = hready_m;
        resp_first = hresp_m;
        waits = 0;
        while (!hready_m && waits < 50) begin
            @(negedge HCLK);
            waits++;
        end
        rdata     = hrdata_m;
        resp_last = hresp_m;
    endtask

    logic [31:0] rd;
    int          w;
    logic        rf, pf, pl;

    initial begin
        // Reset state of both instances
        #12;
        dut_sel = 1'b0; #1;
        check_eq("rst_hready0", 32'(hready_m), 32'd1);
        check_eq("rst_hresp0",  32'(hresp_m),  32'd0);
        check_eq("rst_hrdata0", hrdata_m,      32'h0);
        dut_sel = 1'b1; #1;
        check_eq("rst_hready3", 32'(hready_m), 32'd1);
        check_eq("rst_hrdata3", hrdata_m,      32'h0);
        dut_sel = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Back-to-back word write then read of the same word, zero waits
        @(negedge HCLK);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
        @(negedge HCLK);
        check_eq("b2b_wr_hready", 32'(hready_m), 32'd1);
        hwdata = 32'hDEADBEEF; hwrite = 1'b0;
        @(negedge HCLK);
        hsel = 1'b0; htrans = 2'b00;
        check_eq("b2b_rd_hready", 32'(hready_m), 32'd1);
        check_eq("b2b_fwd_data",  hrdata_m,      32'hDEADBEEF);
        check_eq("b2b_rd_hresp",  32'(hresp_m),  32'd0);

        // Byte write to lane 3 over a full word
        ahb_xfer(1'b1, 32'h10, 3'd2, 32'h11223344, rd, w, rf, pf, pl);
        check_eq("wr_word_waits", 32'(w), 32'd0);
        ahb_xfer(1'b1, 32'h13, 3'd0, 32'hAA000000, rd, w, rf, pf, pl);
        check_eq("wr_byte_resp", 32'(pl), 32'd0);
        ahb_xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, w, rf, pf, pl);
        check_eq("byte_lane3", rd, 32'hAA223344);

        // Halfword to lanes 2-3, then byte to lane 0
        ahb_xfer(1'b1, 32'h12, 3'd1, 32'h55660000, rd, w, rf, pf, pl);
        ahb_xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, w, rf, pf, pl);
        check_eq("half_upper", rd, 32'h55663344);
        ahb_xfer(1'b1, 32'h10, 3'd0, 32'hFFFFFFEE, rd, w, rf, pf, pl);
        ahb_xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, w, rf, pf, pl);
        check_eq("byte_lane0", rd, 32'h556633EE);

        // Error responses: out of range, misaligned halfword, oversized
        ahb_xfer(1'b1, 32'h0, 3'd2, 32'h01020304, rd, w, rf, pf, pl);
        ahb_xfer(1'b0, 32'h0001_0000, 3'd2, 32'h0, rd, w, rf, pf, pl);
        check_eq("oor_hready1", 32'(rf), 32'd0);
        check_eq("oor_hresp1",  32'(pf), 32'd1);
        check_eq("oor_hresp2",  32'(pl), 32'd1);
        check_eq("oor_waits",   32'(w),  32'd1);
        check_eq("oor_hrdata",  rd,      32'h0);
        ahb_xfer(1'b1, 32'h1, 3'd1, 32'hFFFFFFFF, rd, w, rf, pf, pl);
        check_eq("mis_hready1", 32'(rf), 32'd0);
        check_eq("mis_hresp1",  32'(pf), 32'd1);
        check_eq("mis_hresp2",  32'(pl), 32'd1);
        ahb_xfer(1'b1, 32'h0, 3'd3, 32'hFFFFFFFF, rd, w, rf, pf, pl);
        check_eq("big_hresp1", 32'(pf), 32'd1);
        ahb_xfer(1'b0, 32'h0, 3'd2, 32'h0, rd, w, rf, pf, pl);
        check_eq("err_no_write", rd, 32'h01020304);
        check_eq("ok_after_err", 32'(pl), 32'd0);

        // Three wait states
        dut_sel = 1'b1;
        ahb_xfer(1'b1, 32'h20, 3'd2, 32'hCAFEF00D, rd, w, rf, pf, pl);
        check_eq("ws3_wr_waits", 32'(w), 32'd3);
        ahb_xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, w, rf, pf, pl);
        check_eq("ws3_rd_waits",  32'(w),  32'd3);
        check_eq("ws3_rd_first",  32'(rf), 32'd0);
        check_eq("ws3_rd_data",   rd,      32'hCAFEF00D);
        check_eq("ws3_rd_hresp",  32'(pl), 32'd0);

        // Reset in the middle of a waited write aborts it
        @(negedge HCLK);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
        @(negedge HCLK);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
        check_eq("abort_in_wait", 32'(hready_m), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check_eq("abort_hready", 32'(hready_m), 32'd1);
        check_eq("abort_hresp",  32'(hresp_m),  32'd0);
        check_eq("abort_hrdata", hrdata_m,      32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        ahb_xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, w, rf, pf, pl);
        check_eq("abort_old_data", rd, 32'hCAFEF00D);

        repeat (2) @(negedge HCLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
